// File: rtl/morse_pulse_classifier.sv
// Morse key line to classified dit/dash/space events with duration, FIFO-buffered.
// Define MORSE_ADAPTIVE_TIMING_EN to track the dit unit from measured dits.
module morse_pulse_classifier #(
    parameter int CNT_W      = 12,
    parameter int DEBOUNCE_W = 4,
    parameter int DIT_UNIT   = 60,
    parameter int DASH_T     = 120,
    parameter int LETTER_T   = 120,
    parameter int WORD_T     = 300,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clock_1khz,
    input  logic             rst,
    input  logic             morse_in,
    input  logic             event_ready,
    output logic             event_valid,
    output logic [2:0]       event_code,
    output logic [CNT_W-1:0] event_duration,
    output logic             level_out,
    output logic             overflow
);

    localparam int DB_W  = $clog2(DEBOUNCE_W + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int THR_W = CNT_W + 3;

    localparam logic [2:0] EV_NONE   = 3'd0;
    localparam logic [2:0] EV_DIT    = 3'd1;
    localparam logic [2:0] EV_DASH   = 3'd2;
    localparam logic [2:0] EV_LETTER = 3'd3;
    localparam logic [2:0] EV_WORD   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic             sync_a;
    logic             sync_b;
    logic [DB_W-1:0]  db_cnt;

    logic             level_d;
    logic             level_chg;
    logic             level_fall;
    logic [CNT_W-1:0] dur_cnt;
    logic [THR_W-1:0] cnt_ext;
    logic             seen_mark;

    logic [THR_W-1:0] dash_thr;
    logic [THR_W-1:0] letter_thr;
    logic [THR_W-1:0] word_thr;

    logic             cls_push;
    logic [2:0]       cls_code;
    logic             ev_push;
    logic [2:0]       ev_code;
    logic [CNT_W-1:0] ev_dur;

    logic [2:0]       mem_code [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_dur  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W:0]   fcnt;
    logic [PTR_W:0]   fcnt_next;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             load_push;

    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= morse_in;
            sync_b <= sync_a;
        end
    end

    // Level flips only after DEBOUNCE_W consecutive disagreeing samples.
    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            level_out <= 1'b0;
        end else if (sync_b != level_out) begin
            if (db_cnt == DB_W'(DEBOUNCE_W - 1)) begin
                level_out <= sync_b;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

`ifdef MORSE_ADAPTIVE_TIMING_EN
    logic [CNT_W-1:0] unit_q;

    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            unit_q <= CNT_W'(DIT_UNIT);
        end else if (cls_push && cls_code == EV_DIT) begin
            unit_q <= unit_q - (unit_q >> 2) + (dur_cnt >> 2);
        end
    end

    assign dash_thr   = THR_W'({unit_q, 1'b0});
    assign letter_thr = THR_W'({unit_q, 1'b0});
    assign word_thr   = THR_W'({unit_q, 2'b00}) + THR_W'(unit_q);
`else
    assign dash_thr   = THR_W'(DASH_T);
    assign letter_thr = THR_W'(LETTER_T);
    assign word_thr   = THR_W'(WORD_T);
`endif

    assign level_chg  = level_d ^ level_out;
    assign level_fall = level_d & ~level_out;
    assign cnt_ext    = THR_W'(dur_cnt);

    always_comb begin
        cls_push = 1'b0;
        cls_code = EV_NONE;
        if (level_fall) begin
            cls_push = 1'b1;
            cls_code = (cnt_ext >= dash_thr) ? EV_DASH : EV_DIT;
        end else if (!level_chg && !level_out && seen_mark) begin
            if (cnt_ext == letter_thr) begin
                cls_push = 1'b1;
                cls_code = EV_LETTER;
            end else if (cnt_ext == word_thr) begin
                cls_push = 1'b1;
                cls_code = EV_WORD;
            end
        end
    end

    // Classified event is registered here; the count before reload is its duration.
    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            level_d   <= 1'b0;
            dur_cnt   <= '0;
            seen_mark <= 1'b0;
            ev_push   <= 1'b0;
            ev_code   <= EV_NONE;
            ev_dur    <= '0;
        end else begin
            level_d <= level_out;
            ev_push <= cls_push;
            ev_code <= cls_code;
            ev_dur  <= dur_cnt;
            if (level_chg) begin
                dur_cnt <= CNT_W'(1);
            end else if (dur_cnt != CNT_MAX) begin
                dur_cnt <= dur_cnt + CNT_W'(1);
            end
            if (level_fall) begin
                seen_mark <= 1'b1;
            end
        end
    end

    assign full      = (fcnt == FULL_CNT);
    assign pop       = event_valid & event_ready;
    assign push_ok   = ev_push & (~full | pop);
    assign rd_next   = rd_ptr + PTR_W'(pop);
    assign load_push = push_ok & ((fcnt == '0) | (pop & (fcnt == (PTR_W + 1)'(1))));

    always_comb begin
        fcnt_next = fcnt;
        if (push_ok && !pop) begin
            fcnt_next = fcnt + (PTR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            fcnt_next = fcnt - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clock_1khz) begin
        if (push_ok) begin
            mem_code[wr_ptr] <= ev_code;
            mem_dur[wr_ptr]  <= ev_dur;
        end
    end

    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            fcnt   <= fcnt_next;
            rd_ptr <= rd_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ev_push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head register mirrors mem[rd_ptr]; bypass when the pushed entry becomes the head.
    always_ff @(posedge clock_1khz or posedge rst) begin
        if (rst) begin
            event_valid    <= 1'b0;
            event_code     <= EV_NONE;
            event_duration <= '0;
        end else begin
            event_valid <= (fcnt_next != '0);
            if (fcnt_next == '0) begin
                event_code     <= EV_NONE;
                event_duration <= '0;
            end else if (load_push) begin
                event_code     <= ev_code;
                event_duration <= ev_dur;
            end else if (pop) begin
                event_code     <= mem_code[rd_next];
                event_duration <= mem_dur[rd_next];
            end
        end
    end

endmodule

// File: tb/tb_morse_pulse_classifier.sv
// Self-checking bench for morse_pulse_classifier against a segment-level event model.
// Build with MORSE_ADAPTIVE_TIMING_EN to exercise adaptive timing.
module tb_morse_pulse_classifier;

    localparam int CNT_W    = 12;
    localparam int DB       = 4;
    localparam int DIT_UNIT = 60;
    localparam int DASH_T   = 120;
    localparam int LETTER_T = 120;
    localparam int WORD_T   = 300;

    logic             clk = 1'b0;
    logic             rst;
    logic             morse_in;
    logic             event_ready;
    logic             event_valid;
    logic [2:0]       event_code;
    logic [CNT_W-1:0] event_duration;
    logic             level_out;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int q_code[$];
    int q_dur[$];
    int q_cyc[$];
    int e_code[$];
    int e_dur[$];
    int segs[$];

    morse_pulse_classifier #(
        .CNT_W(CNT_W), .DEBOUNCE_W(DB), .DIT_UNIT(DIT_UNIT),
        .DASH_T(DASH_T), .LETTER_T(LETTER_T), .WORD_T(WORD_T),
        .FIFO_DEPTH(8)
    ) dut (
        .clock_1khz(clk),
        .rst(rst),
        .morse_in(morse_in),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_code(event_code),
        .event_duration(event_duration),
        .level_out(level_out),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (event_valid && event_ready) begin
            q_code.push_back(int'(event_code));
            q_dur.push_back(int'(event_duration));
            q_cyc.push_back(cyc);
        end
    end

    task automatic hold(input logic lvl, input int n);
        morse_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q;
        q_code.delete();
        q_dur.delete();
        q_cyc.delete();
    endtask

    task automatic play;
        for (int i = 0; i < segs.size(); i++)
            hold((i % 2) == 0, segs[i]);
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        morse_in = 1'b0;
        event_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 3);
    endtask

    // Expected events from mark/gap lengths: segs alternates mark, gap.
    task automatic run_model;
        int u, m, g, d_t, l_t, w_t;
        e_code.delete();
        e_dur.delete();
        u = DIT_UNIT;
        for (int i = 0; i + 1 < segs.size(); i += 2) begin
            m = segs[i];
            g = segs[i+1];
`ifdef MORSE_ADAPTIVE_TIMING_EN
            d_t = 2 * u;
`else
            d_t = DASH_T;
`endif
            if (m >= d_t) begin
                e_code.push_back(2);
            end else begin
                e_code.push_back(1);
`ifdef MORSE_ADAPTIVE_TIMING_EN
                u = u - u / 4 + m / 4;
`endif
            end
            e_dur.push_back(m);
`ifdef MORSE_ADAPTIVE_TIMING_EN
            l_t = 2 * u;
            w_t = 5 * u;
`else
            l_t = LETTER_T;
            w_t = WORD_T;
`endif
            if (g > l_t) begin
                e_code.push_back(3);
                e_dur.push_back(l_t);
            end
            if (g > w_t) begin
                e_code.push_back(4);
                e_dur.push_back(w_t);
            end
        end
    endtask

    task automatic test_reset;
        apply_reset();
        n_checks++;
        if (event_valid !== 1'b0 || event_code !== 3'd0 || event_duration !== '0) begin
            n_fail++;
            $display("FAIL reset_head: valid=%b code=%0d dur=%0d, required 0/0/0",
                     event_valid, event_code, event_duration);
        end
        n_checks++;
        if (level_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: level=%b ovf=%b, required 0/0", level_out, overflow);
        end
        clear_q();
        hold(1'b0, 400);
        n_checks++;
        if (q_code.size() != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset: %0d events, required 0", q_code.size());
        end
    endtask

    task automatic test_dit_spaces;
        int t_fall;
        segs = '{60, 400};
        run_model();
        clear_q();
        hold(1'b1, 60);
        t_fall = cyc;
        hold(1'b0, 400);
        hold(1'b0, 100);
        n_checks++;
        if (q_code.size() != e_code.size()) begin
            n_fail++;
            $display("FAIL dit_spaces_count: %0d events, required %0d", q_code.size(), e_code.size());
        end
        for (int i = 0; i < e_code.size() && i < q_code.size(); i++) begin
            n_checks++;
            if (q_code[i] != e_code[i] || q_dur[i] != e_dur[i]) begin
                n_fail++;
                $display("FAIL dit_spaces_ev%0d: code=%0d dur=%0d, required code=%0d dur=%0d",
                         i, q_code[i], q_dur[i], e_code[i], e_dur[i]);
            end
        end
        if (q_cyc.size() >= 3) begin
            n_checks++;
            if (q_cyc[0] != t_fall + DB + 4) begin
                n_fail++;
                $display("FAIL latency: event at cycle %0d, required %0d", q_cyc[0], t_fall + DB + 4);
            end
            n_checks++;
            if (q_cyc[2] <= q_cyc[1]) begin
                n_fail++;
                $display("FAIL space_order: word at %0d, letter at %0d", q_cyc[2], q_cyc[1]);
            end
        end
    endtask

    task automatic test_thresholds;
        segs = '{180, 400, 120, 400, 119, 400};
        run_model();
        clear_q();
        play();
        hold(1'b0, 30);
        n_checks++;
        if (q_code.size() != e_code.size()) begin
            n_fail++;
            $display("FAIL thr_count: %0d events, required %0d", q_code.size(), e_code.size());
        end
        for (int i = 0; i < e_code.size() && i < q_code.size(); i++) begin
            n_checks++;
            if (q_code[i] != e_code[i] || q_dur[i] != e_dur[i]) begin
                n_fail++;
                $display("FAIL thr_ev%0d: code=%0d dur=%0d, required code=%0d dur=%0d",
                         i, q_code[i], q_dur[i], e_code[i], e_dur[i]);
            end
        end
    endtask

    task automatic test_glitch;
        int bad;
        bad = 0;
        clear_q();
        hold(1'b1, 2);
        morse_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (level_out !== 1'b0) bad++;
        end
        hold(1'b0, 20);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL glitch_level: level high on %0d cycles, required 0", bad);
        end
        n_checks++;
        if (q_code.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_events: %0d events, required 0", q_code.size());
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 3; r++) begin
            segs.delete();
            for (int k = 0; k < 6; k++) begin
                segs.push_back(int'($urandom_range(10, 250)));
                case ($urandom_range(0, 2))
                    0: segs.push_back(int'($urandom_range(10, 110)));
                    1: segs.push_back(int'($urandom_range(130, 290)));
                    default: segs.push_back(int'($urandom_range(310, 450)));
                endcase
            end
            segs[segs.size()-1] = 400;
            run_model();
            clear_q();
            play();
            hold(1'b0, 30);
            n_checks++;
            if (q_code.size() != e_code.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: %0d events, required %0d", r, q_code.size(), e_code.size());
            end
            for (int i = 0; i < e_code.size() && i < q_code.size(); i++) begin
                n_checks++;
                if (q_code[i] != e_code[i] || q_dur[i] != e_dur[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_ev%0d: code=%0d dur=%0d, required code=%0d dur=%0d",
                             r, i, q_code[i], q_dur[i], e_code[i], e_dur[i]);
                end
            end
        end
    endtask

    task automatic test_overflow;
        clear_q();
        event_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hold(1'b1, 60);
            hold(1'b0, 50);
        end
        hold(1'b0, 400);
        n_checks++;
        if (overflow !== 1'b1 || event_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: ovf=%b valid=%b, required 1/1", overflow, event_valid);
        end
        event_ready = 1'b1;
        hold(1'b0, 20);
        n_checks++;
        if (q_code.size() != 8) begin
            n_fail++;
            $display("FAIL ovf_count: %0d drained, required 8", q_code.size());
        end
        for (int i = 0; i < q_code.size(); i++) begin
            n_checks++;
            if (q_code[i] != 1 || q_dur[i] != 60 || q_cyc[i] != q_cyc[0] + i) begin
                n_fail++;
                $display("FAIL ovf_ev%0d: code=%0d dur=%0d cyc=%0d, required dit 60 cyc=%0d",
                         i, q_code[i], q_dur[i], q_cyc[i], q_cyc[0] + i);
            end
        end
        n_checks++;
        if (event_valid !== 1'b0 || event_code !== 3'd0 || event_duration !== '0) begin
            n_fail++;
            $display("FAIL ovf_empty: valid=%b code=%0d dur=%0d, required 0/0/0",
                     event_valid, event_code, event_duration);
        end
    endtask

    task automatic test_reset_mid_mark;
        clear_q();
        hold(1'b1, 30);
        rst = 1'b1;
        morse_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b0, 500);
        n_checks++;
        if (q_code.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mark_events: %0d events, required 0", q_code.size());
        end
        n_checks++;
        if (overflow !== 1'b0 || event_valid !== 1'b0 || event_code !== 3'd0 ||
            event_duration !== '0 || level_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mark_outputs: ovf=%b valid=%b code=%0d dur=%0d level=%b, required all 0",
                     overflow, event_valid, event_code, event_duration, level_out);
        end
    endtask

    task automatic test_adaptive;
        int exp_last;
`ifdef MORSE_ADAPTIVE_TIMING_EN
        exp_last = 2;
`else
        exp_last = 1;
`endif
        apply_reset();
        segs.delete();
        for (int i = 0; i < 8; i++) begin
            segs.push_back(40);
            segs.push_back(40);
        end
        segs.push_back(100);
        segs.push_back(400);
        run_model();
        clear_q();
        play();
        hold(1'b0, 30);
        n_checks++;
        if (q_code.size() != e_code.size()) begin
            n_fail++;
            $display("FAIL adapt_count: %0d events, required %0d", q_code.size(), e_code.size());
        end
        for (int i = 0; i < e_code.size() && i < q_code.size(); i++) begin
            n_checks++;
            if (q_code[i] != e_code[i] || q_dur[i] != e_dur[i]) begin
                n_fail++;
                $display("FAIL adapt_ev%0d: code=%0d dur=%0d, required code=%0d dur=%0d",
                         i, q_code[i], q_dur[i], e_code[i], e_dur[i]);
            end
        end
        if (q_code.size() > 8) begin
            n_checks++;
            if (q_code[8] != exp_last || q_dur[8] != 100) begin
                n_fail++;
                $display("FAIL adapt_last_mark: code=%0d dur=%0d, required code=%0d dur=100",
                         q_code[8], q_dur[8], exp_last);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        morse_in = 1'b0;
        event_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
`ifndef MORSE_ADAPTIVE_TIMING_EN
        test_dit_spaces();
        test_thresholds();
        test_glitch();
        test_random();
        test_overflow();
`endif
        test_reset_mid_mark();
        test_adaptive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
